// File: rtl/prog_loader.sv
// Serial program loader: receives an 8N1 UART image frame and writes it into instruction RAM while holding the CPU.
// Optional checksum byte and XOR check are built when LOADER_CHECKSUM_EN is defined.
module prog_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  input  logic              load_req,
  output logic              cpu_hold,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {
    IDLE, HDR, LEN_H, LEN_L, DATA_H, DATA_L,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;

  logic [1:0]       r_rxd_sync;
  logic             r_rxd_prev;
  logic [1:0]       r_req_sync;
  logic             w_rxd;
  logic             w_req;

  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_byte;
  logic             r_rx_valid;
  logic             r_rx_ferr;

  state_t           r_state;
  logic [15:0]      r_len;
  logic [7:0]       r_hi;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       r_chk;
`endif
  logic [15:0]      w_len_n;
  logic [15:0]      w_wc_next;

  assign w_rxd     = r_rxd_sync[1];
  assign w_req     = r_req_sync[1];
  assign w_len_n   = {r_len[15:8], r_rx_byte};
  assign w_wc_next = word_count + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxd_sync <= 2'b11;
      r_rxd_prev <= 1'b1;
      r_req_sync <= 2'b00;
    end else begin
      r_rxd_sync <= {r_rxd_sync[0], rxd};
      r_rxd_prev <= w_rxd;
      r_req_sync <= {r_req_sync[0], load_req};
    end
  end

  // UART receiver: start confirmed at half bit, then one sample per bit period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rxd && r_rxd_prev) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF_M1) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= w_rxd ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == FULL_M1) begin
            r_rx_cnt  <= '0;
            r_rx_byte <= {w_rxd, r_rx_byte[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: begin
          if (r_rx_cnt == FULL_M1) begin
            r_rx_cnt   <= '0;
            r_rx_valid <= 1'b1;
            r_rx_ferr  <= !w_rxd;
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Frame FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_hi       <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_chk      <= '0;
`endif
      cpu_hold   <= 1'b0;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      mem_wren <= 1'b0;
      case (r_state)
        IDLE: begin
          cpu_hold <= 1'b0;
          if (w_req) begin
            r_state    <= HDR;
            cpu_hold   <= 1'b1;
            word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_chk      <= '0;
`endif
          end
        end
        DONE, ERR: begin
          if (!w_req) begin
            r_state  <= IDLE;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        default: begin
          if (!w_req) begin
            r_state  <= IDLE;
            cpu_hold <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
          end else if (r_rx_valid) begin
            if (r_rx_ferr && r_state != HDR) begin
              r_state <= ERR;
              err     <= 1'b1;
            end else begin
              case (r_state)
                HDR: if (!r_rx_ferr && r_rx_byte == 8'hA5) r_state <= LEN_H;
                LEN_H: begin
                  r_len[15:8] <= r_rx_byte;
                  r_state     <= LEN_L;
                end
                LEN_L: begin
                  r_len <= w_len_n;
                  if ({1'b0, w_len_n} > MAX_WORDS) begin
                    r_state <= ERR;
                    err     <= 1'b1;
                  end else if (w_len_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                    r_state <= CHK;
`else
                    r_state <= DONE;
                    done    <= 1'b1;
`endif
                  end else begin
                    r_state <= DATA_H;
                  end
                end
                DATA_H: begin
                  r_hi    <= r_rx_byte;
`ifdef LOADER_CHECKSUM_EN
                  r_chk   <= r_chk ^ r_rx_byte;
`endif
                  r_state <= DATA_L;
                end
                DATA_L: begin
                  mem_wren   <= 1'b1;
                  mem_data   <= {r_hi, r_rx_byte};
                  mem_addr   <= word_count[ADDR_W-1:0];
                  word_count <= w_wc_next;
`ifdef LOADER_CHECKSUM_EN
                  r_chk      <= r_chk ^ r_rx_byte;
                  r_state    <= (w_wc_next == r_len) ? CHK : DATA_H;
`else
                  if (w_wc_next == r_len) begin
                    r_state <= DONE;
                    done    <= 1'b1;
                  end else begin
                    r_state <= DATA_H;
                  end
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                  if (r_rx_byte == r_chk) begin
                    r_state <= DONE;
                    done    <= 1'b1;
                  end else begin
                    r_state <= ERR;
                    err     <= 1'b1;
                  end
                end
`endif
                default: r_state <= r_state;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader at CLKS_PER_BIT=4, ADDR_W=4; checksum scenarios follow LOADER_CHECKSUM_EN.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxd = 1'b1;
  logic        load_req = 1'b0;
  logic        cpu_hold, mem_wren, done, err;
  logic [3:0]  mem_addr;
  logic [15:0] mem_data, word_count;

  int n_checks = 0;
  int n_errors = 0;
  int wr_n = 0;
  int base;
  logic [3:0]  wr_addr [64];
  logic [15:0] wr_data [64];

  prog_loader #(.CLKS_PER_BIT(4), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .load_req(load_req),
    .cpu_hold(cpu_hold), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_data(mem_data), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wren && wr_n < 64) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_data;
      wr_n = wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (4) @(negedge clk);
    end
    rxd = stop;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_result(input string tag);
    int i;
    for (i = 0; i < 100; i++) begin
      if (done || err) break;
      @(negedge clk);
    end
    check({tag, "_timeout"}, (i < 100) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic start_load();
    load_req = 1'b1;
    repeat (4) @(negedge clk);
    base = wr_n;
  endtask

  task automatic end_load();
    load_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_hold", cpu_hold, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wc", word_count, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Scenario 1: two-word frame, and load_req->cpu_hold latency
    load_req = 1'b1;
    repeat (2) @(negedge clk);
    check("lat_hold_2clk", cpu_hold, 0);
    @(negedge clk);
    check("lat_hold_3clk", cpu_hold, 1);
    @(negedge clk);
    base = wr_n;
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h02, 1);
    send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'hAB, 1); send_byte(8'hCD, 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h40, 1);
`endif
    wait_result("s1");
    @(negedge clk);
    check("s1_nwr", wr_n - base, 2);
    check("s1_a0", wr_addr[base], 0);
    check("s1_d0", wr_data[base], 16'h1234);
    check("s1_a1", wr_addr[base+1], 1);
    check("s1_d1", wr_data[base+1], 16'hABCD);
    check("s1_done", done, 1);
    check("s1_err", err, 0);
    check("s1_wc", word_count, 2);
    check("s1_hold", cpu_hold, 1);
    check("s1_addr_hold", mem_addr, 1);
    check("s1_data_hold", mem_data, 16'hABCD);
    end_load();
    check("s1_hold_rel", cpu_hold, 0);
    check("s1_done_clr", done, 0);
    check("s1_wc_kept", word_count, 2);

    // Scenario 2: garbage before header
    start_load();
    send_byte(8'h00, 1); send_byte(8'h7F, 1);
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h01, 1);
    send_byte(8'hBE, 1); send_byte(8'hEF, 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h51, 1);
`endif
    wait_result("s2");
    @(negedge clk);
    check("s2_nwr", wr_n - base, 1);
    check("s2_a0", wr_addr[base], 0);
    check("s2_d0", wr_data[base], 16'hBEEF);
    check("s2_done", done, 1);
    check("s2_wc", word_count, 1);
    end_load();

`ifdef LOADER_CHECKSUM_EN
    // Scenario 3: bad checksum
    start_load();
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h02, 1);
    send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'hAB, 1); send_byte(8'hCD, 1);
    send_byte(8'h41, 1);
    wait_result("s3");
    @(negedge clk);
    check("s3_nwr", wr_n - base, 2);
    check("s3_err", err, 1);
    check("s3_done", done, 0);
    end_load();
    check("s3_err_clr", err, 0);
`endif

    // Scenario 4: length too large
    start_load();
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h11, 1);
    wait_result("s4");
    @(negedge clk);
    check("s4_err", err, 1);
    check("s4_done", done, 0);
    check("s4_nwr", wr_n - base, 0);
    check("s4_hold", cpu_hold, 1);
    end_load();

    // Scenario 5: framing error on the low byte of the first word
    start_load();
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h02, 1);
    send_byte(8'h12, 1); send_byte(8'h34, 0);
    wait_result("s5");
    send_byte(8'hAB, 1);
    @(negedge clk);
    check("s5_err", err, 1);
    check("s5_nwr", wr_n - base, 0);
    check("s5_wc", word_count, 0);
    end_load();

    // Scenario 6: abort after the first word
    start_load();
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h02, 1);
    send_byte(8'h12, 1); send_byte(8'h34, 1);
    repeat (4) @(negedge clk);
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    check("s6_hold", cpu_hold, 0);
    check("s6_err", err, 0);
    check("s6_wc", word_count, 1);
    check("s6_nwr", wr_n - base, 1);
    repeat (4) @(negedge clk);

    // Scenario 7: asynchronous reset mid-byte, then a clean load
    start_load();
    send_byte(8'hA5, 1);
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("s7_hold", cpu_hold, 0);
    check("s7_wc", word_count, 0);
    check("s7_addr", mem_addr, 0);
    check("s7_data", mem_data, 0);
    check("s7_flags", {30'd0, done, err}, 0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    base = wr_n;
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h01, 1);
    send_byte(8'hBE, 1); send_byte(8'hEF, 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h51, 1);
`endif
    wait_result("s7");
    @(negedge clk);
    check("s7_done", done, 1);
    check("s7_nwr", wr_n - base, 1);
    check("s7_d0", wr_data[base], 16'hBEEF);
    check("s7_wc1", word_count, 1);
    end_load();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1);
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader upstream of the processor's instruction memory. Receives a framed program image over an 8N1 UART line and writes it word-by-word into instruction RAM. Holds the processor stopped while loading. Lets a new program be downloaded without resynthesising the memory init file.

## Interface
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4.
- ADDR_W, 12, instruction-memory address width; capacity 2^ADDR_W words.

- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- rxd  in  1  UART receive line, asynchronous, idle high; 2-flop synchronized internally.
- load_req  in  1  level request (switch), asynchronous; 2-flop synchronized internally.
- cpu_hold  out  1  high = processor must stay in phase 0 / be held.
- mem_wren  out  1  one-cycle write strobe to instruction RAM.
- mem_addr  out  ADDR_W  write address (word index).
- mem_data  out  16  write data.
- done  out  1  image loaded and verified; sticky until load_req low.
- err  out  1  frame or checksum error; sticky until load_req low.
- word_count  out  16  words written in current or last load.

## Operation
- Frame: 0xA5 header, N high byte, N low byte, then N words (high byte first), then one checksum byte. The checksum is the XOR of all data bytes.
- UART RX:
  - Idle until a synchronized falling edge on rxd.
  - Re-sample at CLKS_PER_BIT/2; if rxd is high, the start is false and RX returns to idle.
  - Sample 8 data bits LSB first, each CLKS_PER_BIT apart, then the stop bit.
  - A stop bit of 0 is a framing error.
  - byte_valid pulses for one cycle at the stop-bit sample.
- FSM states: IDLE, HDR, LEN_H, LEN_L, DATA_H, DATA_L, CHK, DONE, ERR.
- IDLE:
  - Outputs: cpu_hold=0, word_count held.
  - On load_req=1 go to HDR; clear word_count and the checksum accumulator.
- HDR:
  - A byte equal to 0xA5 moves to LEN_H.
  - Any other byte is discarded and the FSM stays in HDR (resync).
- LEN_H then LEN_L latch N.
  - N > 2^ADDR_W goes to ERR.
  - N = 0 goes straight to CHK.
- DATA_H latches the high byte.
- DATA_L, on its byte:
  - mem_data = {hi, lo}, mem_addr = word index, mem_wren pulses.
  - word_count increments.
  - Go to DATA_H, or to CHK after the Nth word.
- CHK: the received byte is compared to the accumulated XOR; a match goes to DONE, otherwise ERR.
- Framing error in any state from LEN_H through CHK goes to ERR.
- DONE/ERR:
  - cpu_hold=1, done or err=1.
  - On load_req=0 return to IDLE; done and err clear.
- cpu_hold=1 in every state except IDLE.
- load_req falling in HDR..CHK aborts to IDLE with err=0. Memory already written is left as is.

## Timing
- Reset values:
  - Outputs: cpu_hold=0, mem_wren=0, mem_addr=0, mem_data=0, done=0, err=0, word_count=0.
  - Internal: FSM in IDLE, RX idle.
- load_req to cpu_hold rising: 3 clk (2 sync + 1 register).
- mem_wren is asserted in the cycle after the low byte's byte_valid.
  - mem_addr and mem_data are registered and stable in that same cycle.
  - Both hold their values until the next write.
- word_count updates in the same cycle as mem_wren.
- done/err rise the cycle after the checksum byte_valid.
- rxd activity while in IDLE, DONE or ERR is ignored by the FSM.
- The RX counter keeps running; no byte is carried over into a new load.
- Asynchronous reset mid-frame returns everything to reset values immediately.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - Checksum byte expected; CHK state present; mismatch goes to ERR.
- Not defined:
  - No checksum byte in the frame; the last DATA_L goes directly to DONE.
  - N = 0 goes directly to DONE.
  - The XOR accumulator is not built.

## Test plan
All scenarios use CLKS_PER_BIT=4, ADDR_W=4.

- Reset, then load_req=1, then frame A5 00 02 12 34 AB CD chk=0x40 -> writes [0]=0x1234, [1]=0xABCD; done=1; word_count=2; cpu_hold=1 until load_req=0.
- Garbage 0x00 0x7F before A5, then a valid 1-word frame 0xBEEF -> garbage ignored; one write at addr 0; done=1.
- Same frame as the first scenario with checksum byte 0x41 -> both writes occur; err=1, done=0.
- N=0x0011 (17 > 16) -> err=1 after LEN_L; no mem_wren.
- Stop bit forced low on the second data byte -> err=1; no write for that word.
- load_req dropped after the first word of a 2-word frame -> cpu_hold=0 within 3 clk; err=0; word_count=1.
- rst pulsed low mid-byte -> all outputs return to reset values; the next frame loads correctly.
